// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file -- CPU general register file with NZCV flag register and
//             condition-code evaluation.
//
// Parameters
//   DATA_W    register / data width in bits
//   NUM_REGS  number of general registers (ADDR_W = clog2(NUM_REGS))
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   reset      synchronous, active-high; clears registers and flags
//   rd_addr_a  read port A select     -> rd_data_a (ALU operand A)
//   rd_addr_b  read port B select     -> rd_data_b (ALU operand B)
//   wr_en      register write enable
//   wr_addr    write register select
//   wr_data    write data (ALU result), also forwarded to matching reads
//   flags_en   flag register update enable
//   flags_in   NZCV from the ALU: [3]=N [2]=Z [1]=C [0]=V
//   flags_out  registered NZCV, same bit order
//   carry_in   flags_out[1], feeds the ALU carry/borrow-in
//   cond       4-bit condition code
//   cond_pass  1 when cond holds for the registered flags
//
// Reads are combinational. A write to the register being read in the same
// cycle is forwarded (each port independently), so an instruction that
// consumes the previous result sees it without a stall. Flags are never
// forwarded: a compare's result is visible to cond_pass one cycle later.
// Addresses at or above NUM_REGS read as zero and are never written.
// ---------------------------------------------------------------------------
module reg_file #(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 8,
    localparam int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flags_en,
    input  logic [3:0]        flags_in,
    output logic [3:0]        flags_out,
    output logic              carry_in,
    input  logic [3:0]        cond,
    output logic              cond_pass
);

    // Condition code encodings
    localparam logic [3:0] CC_EQ = 4'd0;
    localparam logic [3:0] CC_NE = 4'd1;
    localparam logic [3:0] CC_CS = 4'd2;
    localparam logic [3:0] CC_CC = 4'd3;
    localparam logic [3:0] CC_MI = 4'd4;
    localparam logic [3:0] CC_PL = 4'd5;
    localparam logic [3:0] CC_VS = 4'd6;
    localparam logic [3:0] CC_VC = 4'd7;
    localparam logic [3:0] CC_HI = 4'd8;
    localparam logic [3:0] CC_LS = 4'd9;
    localparam logic [3:0] CC_GE = 4'd10;
    localparam logic [3:0] CC_LT = 4'd11;
    localparam logic [3:0] CC_GT = 4'd12;
    localparam logic [3:0] CC_LE = 4'd13;
    localparam logic [3:0] CC_AL = 4'd14;
    localparam logic [3:0] CC_NV = 4'd15;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [3:0]        flags_q;

    // Address range checks. When NUM_REGS is a power of two these are
    // always true and fold away; otherwise they mask the unused codes.
    logic wr_addr_ok;
    logic rd_addr_a_ok;
    logic rd_addr_b_ok;

    assign wr_addr_ok   = (int'(wr_addr)   < NUM_REGS);
    assign rd_addr_a_ok = (int'(rd_addr_a) < NUM_REGS);
    assign rd_addr_b_ok = (int'(rd_addr_b) < NUM_REGS);

    // Effective write strobe: an out-of-range write is dropped here, which
    // also keeps it from being forwarded to a read of the same code.
    logic wr_fire;
    assign wr_fire = wr_en && wr_addr_ok;

    // -----------------------------------------------------------------------
    // Register write (reset wins over a same-cycle write)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Flag register (independent of the register write)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (flags_en) begin
            flags_q <= flags_in;
        end
    end

    assign flags_out = flags_q;
    assign carry_in  = flags_q[1];

    // -----------------------------------------------------------------------
    // Read ports with write forwarding. Forwarding is not gated by reset:
    // during reset the in-flight write still appears on the read port even
    // though it is never stored.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;

    always_comb begin
        stored_a = '0;
        stored_b = '0;
        if (rd_addr_a_ok) begin
            stored_a = regs[rd_addr_a];
        end
        if (rd_addr_b_ok) begin
            stored_b = regs[rd_addr_b];
        end
    end

    always_comb begin
        rd_data_a = stored_a;
        rd_data_b = stored_b;
        if (wr_fire && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
        if (wr_fire && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Condition evaluation, strictly on the registered flags
    // -----------------------------------------------------------------------
    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            CC_EQ:   cond_pass = flag_z;
            CC_NE:   cond_pass = !flag_z;
            CC_CS:   cond_pass = flag_c;
            CC_CC:   cond_pass = !flag_c;
            CC_MI:   cond_pass = flag_n;
            CC_PL:   cond_pass = !flag_n;
            CC_VS:   cond_pass = flag_v;
            CC_VC:   cond_pass = !flag_v;
            CC_HI:   cond_pass = flag_c && !flag_z;
            CC_LS:   cond_pass = !flag_c || flag_z;
            CC_GE:   cond_pass = (flag_n == flag_v);
            CC_LT:   cond_pass = (flag_n != flag_v);
            CC_GT:   cond_pass = !flag_z && (flag_n == flag_v);
            CC_LE:   cond_pass = flag_z || (flag_n != flag_v);
            CC_AL:   cond_pass = 1'b1;
            CC_NV:   cond_pass = 1'b0;
            default: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file -- directed self-checking bench for reg_file (defaults:
// DATA_W=16, NUM_REGS=8). Inputs change 1 ns after a rising edge; outputs
// are sampled well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_reg_file;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              flags_en;
    logic [3:0]        flags_in;
    logic [3:0]        flags_out;
    logic              carry_in;
    logic [3:0]        cond;
    logic              cond_pass;

    reg_file #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .flags_en  (flags_en),
        .flags_in  (flags_in),
        .flags_out (flags_out),
        .carry_in  (carry_in),
        .cond      (cond),
        .cond_pass (cond_pass)
    );

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Condition table, written from the NZCV definitions.
    function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cy, v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'd0:    return z;
            4'd1:    return ~z;
            4'd2:    return cy;
            4'd3:    return ~cy;
            4'd4:    return n;
            4'd5:    return ~n;
            4'd6:    return v;
            4'd7:    return ~v;
            4'd8:    return cy & ~z;
            4'd9:    return ~cy | z;
            4'd10:   return ~(n ^ v);
            4'd11:   return n ^ v;
            4'd12:   return ~z & ~(n ^ v);
            4'd13:   return z | (n ^ v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        flags_en = 1'b0;
        flags_in = 4'b0000;
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic set_flags(input logic [3:0] f);
        flags_en = 1'b1;
        flags_in = f;
        tick();
        flags_en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] exp);
        rd_addr_a = a;
        rd_addr_b = a;
        #1;
        check({tag, "_a"}, 32'(rd_data_a), 32'(exp));
        check({tag, "_b"}, 32'(rd_data_b), 32'(exp));
    endtask

    // Register image maintained by the bench from the writes it issues.
    logic [DATA_W-1:0] model [NUM_REGS];

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        logic [3:0] cc_vals [6];
        logic       cc_exp  [6];
        logic [DATA_W-1:0] exp_q [$];

        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        idle_inputs();
        rd_addr_a = '0;
        rd_addr_b = '0;
        cond      = 4'd0;

        // Reset
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Everything reads zero after reset
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_addr_a = ADDR_W'(i);
            rd_addr_b = ADDR_W'(NUM_REGS - 1 - i);
            #1;
            check("rst_rd_a", 32'(rd_data_a), 32'h0);
            check("rst_rd_b", 32'(rd_data_b), 32'h0);
        end
        check("rst_flags", 32'(flags_out), 32'h0);
        check("rst_carry", 32'(carry_in), 32'h0);

        // Post-reset conditions: EQ=0 NE=1 AL=1 NV=0 GE=1 LE=0
        cc_vals = '{4'd0, 4'd1, 4'd14, 4'd15, 4'd10, 4'd13};
        cc_exp  = '{1'b0, 1'b1, 1'b1,  1'b0,  1'b1,  1'b0};
        for (int i = 0; i < 6; i++) begin
            cond = cc_vals[i];
            #1;
            check("rst_cond", 32'(cond_pass), 32'(cc_exp[i]));
        end

        // Write R3, read back on both ports; others stay zero
        write_reg(3'd3, 16'h1234);
        model[3] = 16'h1234;
        read_check("r3", 3'd3, 16'h1234);
        for (int i = 0; i < NUM_REGS; i++) begin
            read_check("r_all", ADDR_W'(i), model[i]);
        end

        // Same-cycle forwarding: port A matches, port B reads R3
        wr_en     = 1'b1;
        wr_addr   = 3'd5;
        wr_data   = 16'hBEEF;
        rd_addr_a = 3'd5;
        rd_addr_b = 3'd3;
        #1;
        check("byp_a", 32'(rd_data_a), 32'hBEEF);
        check("byp_b_other", 32'(rd_data_b), 32'h1234);
        rd_addr_b = 3'd5;
        #1;
        check("byp_both_a", 32'(rd_data_a), 32'hBEEF);
        check("byp_both_b", 32'(rd_data_b), 32'hBEEF);
        tick();
        wr_en = 1'b0;
        model[5] = 16'hBEEF;
        read_check("r5_stored", 3'd5, 16'hBEEF);

        // wr_en=0 must not store
        wr_addr = 3'd6;
        wr_data = 16'hDEAD;
        rd_addr_a = 3'd6;
        #1;
        check("no_wr_rd", 32'(rd_data_a), 32'h0);
        tick();
        read_check("no_wr_hold", 3'd6, 16'h0000);

        // Flags update: invisible in the cycle applied, visible the next
        flags_en = 1'b1;
        flags_in = 4'b0110;
        cond     = 4'd0;
        #1;
        check("flg_same_out", 32'(flags_out), 32'h0);
        check("flg_same_eq", 32'(cond_pass), 32'h0);
        tick();
        flags_en = 1'b0;
        flags_in = 4'b0000;
        #1;
        check("flg_out", 32'(flags_out), 32'h6);
        check("flg_carry", 32'(carry_in), 32'h1);
        cond = 4'd0; #1; check("flg_eq", 32'(cond_pass), 32'h1);
        cond = 4'd2; #1; check("flg_cs", 32'(cond_pass), 32'h1);
        cond = 4'd8; #1; check("flg_hi", 32'(cond_pass), 32'h0);
        cond = 4'd9; #1; check("flg_ls", 32'(cond_pass), 32'h1);

        // Full flags x cond sweep; flags_in held at the complement to show
        // cond_pass depends only on the registered value
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            flags_in = ~4'(f);
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c);
                #1;
                check("sweep", 32'({f[3:0], c[3:0], 3'b0, cond_pass}),
                      32'({f[3:0], c[3:0], 3'b0, cond_ref(4'(f), 4'(c))}));
            end
        end
        flags_in = 4'b0000;

        // Register write and flag update in the same cycle
        wr_en    = 1'b1;
        wr_addr  = 3'd1;
        wr_data  = 16'h5555;
        flags_en = 1'b1;
        flags_in = 4'b1001;
        tick();
        idle_inputs();
        model[1] = 16'h5555;
        read_check("dual_r1", 3'd1, 16'h5555);
        #1;
        check("dual_flags", 32'(flags_out), 32'h9);
        check("dual_carry", 32'(carry_in), 32'h0);

        // Reset beats a same-cycle write; forwarding still shows it
        write_reg(3'd2, 16'h00FF);
        model[2] = 16'h00FF;
        read_check("r2_pre", 3'd2, 16'h00FF);
        reset     = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 3'd2;
        wr_data   = 16'hAAAA;
        flags_en  = 1'b1;
        flags_in  = 4'b1111;
        rd_addr_a = 3'd2;
        rd_addr_b = 3'd3;
        #1;
        check("rst_byp_a", 32'(rd_data_a), 32'hAAAA);
        check("rst_byp_b", 32'(rd_data_b), 32'h1234);
        tick();
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

        for (int i = 0; i < NUM_REGS; i++) exp_q.push_back(model[i]);
        for (int i = 0; i < NUM_REGS; i++) begin
            read_check("post_rst", ADDR_W'(i), exp_q.pop_front());
        end
        #1;
        check("post_rst_flags", 32'(flags_out), 32'h0);
        check("post_rst_carry", 32'(carry_in), 32'h0);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 16: register and data width in bits.
REQ-002 Parameter NUM_REGS, default 8: number of general registers; ADDR_W = clog2(NUM_REGS).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 rd_addr_a  input  ADDR_W  read port A register select.
REQ-006 rd_addr_b  input  ADDR_W  read port B register select.
REQ-007 rd_data_a  output  DATA_W  port A read data; drives the ALU A operand.
REQ-008 rd_data_b  output  DATA_W  port B read data; drives the ALU B operand.
REQ-009 wr_en  input  1  register write enable.
REQ-010 wr_addr  input  ADDR_W  write register select.
REQ-011 wr_data  input  DATA_W  write data; ALU result.
REQ-012 flags_en  input  1  flag register update enable.
REQ-013 flags_in  input  4  NZCV from ALU; bit3 N, bit2 Z, bit1 C, bit0 V.
REQ-014 flags_out  output  4  registered NZCV, same bit order.
REQ-015 carry_in  output  1  equals flags_out[1]; drives the ALU carry/borrow-in.
REQ-016 cond  input  4  condition code to evaluate.
REQ-017 cond_pass  output  1  1 when cond holds for flags_out.

Function
REQ-018 Storage: NUM_REGS registers of DATA_W bits plus one 4-bit flag register; no register is hardwired.
REQ-019 Write: when wr_en=1 and reset=0, register[wr_addr] <= wr_data at the rising edge; other registers hold.
REQ-020 Read: rd_data_a/rd_data_b are combinational from rd_addr_a/rd_addr_b; no read latency.
REQ-021 Bypass: when wr_en=1 and rd_addr_x == wr_addr, rd_data_x = wr_data in the same cycle; each port is independent, and both ports bypass when both match.
REQ-022 Flags: when flags_en=1 and reset=0, flags_out <= flags_in at the rising edge; otherwise hold. No flag bypass; a new value is visible the cycle after the update.
REQ-023 wr_en and flags_en are independent; both may update in the same cycle (flags-only updates serve compare operations).
REQ-024 cond decode, on registered flags: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
REQ-025 cond_pass is combinational from cond and flags_out only; it never uses flags_in.
REQ-026 Out-of-range addresses (>= NUM_REGS when not a power of two): reads return 0 and writes are ignored.

Reset
REQ-027 When reset=1 at a rising edge, all registers and flags_out clear to 0; carry_in becomes 0.
REQ-028 Reset has priority over same-cycle wr_en/flags_en; the write is discarded.
REQ-029 During reset, read bypass still applies combinationally; the value is not stored.
REQ-030 After reset, cond_pass=1 for EQ? no: Z=0, so EQ=0, NE=1, AL=1, NV=0, GE=1, LE=0.

Verification
REQ-031 Reset, then read all addresses -> every rd_data=0, flags_out=0000, carry_in=0.
REQ-032 Write R3=0x1234, next cycle rd_addr_a=3, rd_addr_b=3 -> both ports read 0x1234; other registers remain 0.
REQ-033 wr_en=1, wr_addr=5, wr_data=0xBEEF, rd_addr_a=5 in the same cycle -> rd_data_a=0xBEEF combinationally; after the edge, R5 holds 0xBEEF.
REQ-034 flags_en=1, flags_in=0110 -> next cycle flags_out=0110, carry_in=1, cond EQ=1, CS=1, HI=0, LS=1; the flag update has no effect in the cycle it is applied.
REQ-035 Sweep flags_in 0000..1111 x cond 0..15 -> cond_pass matches the REQ-024 table for all 256 combinations.
REQ-036 Write R2=0x00FF, then assert reset and wr_en (R2=0xAAAA) in the same cycle -> R2=0, flags_out=0000 afterwards.
